strided_transpose_buffer: RTL and testbench
===========================================

# strided_transpose_buffer

Parametrised successor to the fixed-size transpose index generator. It accepts row-major tiles over a valid/ready input, stores them in a two-bank ping-pong buffer, and emits columns over a valid/ready output. Column order is set by a strided inner index, and whole-tile replay is set by an outer index. It sits between the memory fetch stage and the processing-element array, so that row fetches feed column consumers without stalling.

## Interface

Parameters:
- WORD_WIDTH, 16, bits per data word
- FETCH_WIDTH, 4, words per input row; also the number of columns per tile; power of two, at least 2
- DEPTH, 4, rows per tile; also the number of words per output column
- IDX_WIDTH, 3, width of range, stride and index signals

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  in_data holds a valid row
- in_ready  out  1  buffer can accept a row
- in_data  in  FETCH_WIDTH*WORD_WIDTH  one row; word i is at bits [i*WORD_WIDTH +: WORD_WIDTH]
- out_valid  out  1  out_data holds a valid column
- out_ready  in  1  consumer accepts the column
- out_data  out  DEPTH*WORD_WIDTH  one column; word r is row r of the read bank at the current column
- range_inner  in  IDX_WIDTH  column reads per pass; 0 is treated as 1
- range_outer  in  IDX_WIDTH  passes per tile; 0 is treated as 1
- stride  in  IDX_WIDTH  column step between successive reads
- index_inner  out  IDX_WIDTH  current read count within the pass
- index_outer  out  IDX_WIDTH  current pass number

## Operation

- Storage: 2 banks × DEPTH rows × FETCH_WIDTH words. Each bank has a state, EMPTY or FULL.
- Write side:
  - in_ready = (bank[wr_sel] == EMPTY).
  - A write occurs when in_valid && in_ready. It stores in_data into row wr_row of bank wr_sel, then increments wr_row.
  - On the write with wr_row == DEPTH-1: bank[wr_sel] becomes FULL, wr_row wraps to 0, and wr_sel toggles.
- Read side:
  - out_valid = (bank[rd_sel] == FULL).
  - col = low log2(FETCH_WIDTH) bits of (index_inner * stride). This is a modulo-FETCH_WIDTH wrap.
  - out_data is combinational from bank[rd_sel] at column col.
- A read beat occurs when out_valid && out_ready:
  - If index_inner != eff_range_inner-1: index_inner increments by 1.
  - Otherwise index_inner becomes 0, and:
    - If index_outer != eff_range_outer-1: index_outer increments by 1 and the tile replays.
    - Otherwise index_outer becomes 0, bank[rd_sel] becomes EMPTY, and rd_sel toggles.
- eff_range = (range == 0) ? 1 : range.
- Counter arithmetic is IDX_WIDTH bits, unsigned, with no saturation.
- range_inner, range_outer and stride must be held stable while out_valid is high. Changing them mid-tile is undefined.
- Simultaneous events:
  - A write completing one bank and a read releasing the other bank in the same cycle both take effect.
  - in_ready and out_valid are both high in the next cycle.
- The bank being read is never written, because a FULL bank is never the write target.
- Reset, when rst_n is low at a rising edge:
  - Both banks become EMPTY.
  - wr_sel, rd_sel and wr_row become 0.
  - index_inner and index_outer become 0.
  - Stored data is not cleared. Any in-flight tile is discarded.

## Timing

- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - index_inner = 0 and index_outer = 0.
  - out_data is don't-care while out_valid = 0.
- Fill latency: if the last row of a tile is written at edge N, out_valid is high in the cycle after edge N.
- Throughput: one row per cycle in and one column per cycle out, provided there is no backpressure.
- Release latency: a bank released at edge N shows in_ready high in the cycle after edge N if that bank is the write target.
- When both banks are FULL, in_ready = 0 until a release.
- in_ready and out_valid depend only on registered state, with no combinational path from the valid/ready inputs.

## Test plan

- Reset: hold rst_n = 0 for 2 cycles mid-stream, then release. Required: in_ready = 1, out_valid = 0, index_inner = 0, index_outer = 0. The next output tile contains only rows written after reset.
- Identity transpose:
  - Stimulus: defaults; write rows r with word i = 16*r + i; range_inner = 4, stride = 1, range_outer = 1; out_ready = 1.
  - Required: columns 0..3 are output, and column c = {48+c, 32+c, 16+c, c}, with word r at row r.
  - Required: out_valid rises the cycle after row 3 is written.
- Stride wrap: range_inner = 4, stride = 2. Required: columns 0, 2, 0, 2. Then the bank releases.
- Replay: range_inner = 2, stride = 1, range_outer = 3. Required: columns 0, 1, 0, 1, 0, 1, with index_outer = 0, 0, 1, 1, 2, 2. Release happens after the 6th beat.
- Backpressure / ping-pong:
  - Stimulus: out_ready = 0; stream 10 rows.
  - Required: in_ready drops after the 8th accepted row.
  - Then raise out_ready for one full tile. Required: in_ready returns 1 the cycle after the release, and the remaining rows are accepted in order.
- Zero ranges: range_inner = 0, range_outer = 0. Required: exactly one beat (column 0) per tile, and the bank releases on that beat.

Source files
------------

// File: rtl/strided_transpose_buffer.sv
// Ping-pong transpose buffer: accepts row-major tiles, emits strided columns
// with optional whole-tile replay.
module strided_transpose_buffer #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IDX_WIDTH   = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FETCH_WIDTH*WORD_WIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DEPTH*WORD_WIDTH-1:0]       out_data,
  input  logic [IDX_WIDTH-1:0]              range_inner,
  input  logic [IDX_WIDTH-1:0]              range_outer,
  input  logic [IDX_WIDTH-1:0]              stride,
  output logic [IDX_WIDTH-1:0]              index_inner,
  output logic [IDX_WIDTH-1:0]              index_outer
);

  localparam int unsigned ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned COL_W    = $clog2(FETCH_WIDTH);
  localparam int unsigned ROW_BITS = FETCH_WIDTH * WORD_WIDTH;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

  bank_state_e          bank_q [2];
  bank_state_e          bank_d [2];
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [ROW_W-1:0]     wr_row_q, wr_row_d;
  logic [IDX_WIDTH-1:0] inner_q, inner_d;
  logic [IDX_WIDTH-1:0] outer_q, outer_d;
  logic [ROW_BITS-1:0]  mem [2][DEPTH];

  logic                 wr_fire, rd_fire;
  logic                 inner_last, outer_last;
  logic [IDX_WIDTH-1:0] eff_inner, eff_outer;
  logic [IDX_WIDTH-1:0] prod;
  logic [COL_W-1:0]     col;

  // Handshake flags come only from registered bank state
  assign in_ready    = (bank_q[wr_sel_q] == EMPTY);
  assign out_valid   = (bank_q[rd_sel_q] == FULL);
  assign index_inner = inner_q;
  assign index_outer = outer_q;

  assign wr_fire    = in_valid && in_ready;
  assign rd_fire    = out_valid && out_ready;
  assign eff_inner  = (range_inner == '0) ? IDX_WIDTH'(1) : range_inner;
  assign eff_outer  = (range_outer == '0) ? IDX_WIDTH'(1) : range_outer;
  assign inner_last = (inner_q == eff_inner - IDX_WIDTH'(1));
  assign outer_last = (outer_q == eff_outer - IDX_WIDTH'(1));
  assign prod       = inner_q * stride;
  assign col        = COL_W'(prod);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_row_q  <= '0;
      inner_q   <= '0;
      outer_q   <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      wr_row_q  <= wr_row_d;
      inner_q   <= inner_d;
      outer_q   <= outer_d;
    end
  end

  // Next-state: write fill and read release touch different banks
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    wr_row_d  = wr_row_q;
    inner_d   = inner_q;
    outer_d   = outer_q;

    if (wr_fire) begin
      if (wr_row_q == ROW_W'(DEPTH - 1)) begin
        wr_row_d         = '0;
        bank_d[wr_sel_q] = FULL;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        wr_row_d = wr_row_q + ROW_W'(1);
      end
    end

    if (rd_fire) begin
      if (!inner_last) begin
        inner_d = inner_q + IDX_WIDTH'(1);
      end else begin
        inner_d = '0;
        if (!outer_last) begin
          outer_d = outer_q + IDX_WIDTH'(1);
        end else begin
          outer_d          = '0;
          bank_d[rd_sel_q] = EMPTY;
          rd_sel_d         = ~rd_sel_q;
        end
      end
    end
  end

  // Row storage; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      mem[wr_sel_q][wr_row_q] <= in_data;
    end
  end

  // Column gather from the read bank
  always_comb begin
    out_data = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      for (int unsigned c = 0; c < FETCH_WIDTH; c++) begin
        if (col == COL_W'(c)) begin
          out_data[r*WORD_WIDTH +: WORD_WIDTH] = mem[rd_sel_q][r][c*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_strided_transpose_buffer.sv
// Directed bench for strided_transpose_buffer with default parameters.
module tb_strided_transpose_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  range_inner, range_outer, stride;
  logic [2:0]  index_inner, index_outer;

  int vectors     = 0;
  int miscompares = 0;

  strided_transpose_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .range_inner(range_inner), .range_outer(range_outer), .stride(stride),
    .index_inner(index_inner), .index_outer(index_outer)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Row r holds words 16*r + i
  function automatic logic [63:0] row_val(input int r);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(16*r + i);
    return v;
  endfunction

  // Column c of a tile whose first row is b
  function automatic logic [63:0] col_val(input int b, input int c);
    logic [63:0] v;
    for (int r = 0; r < 4; r++) v[r*16 +: 16] = 16'(16*(b + r) + c);
    return v;
  endfunction

  task automatic write_row(input int r);
    int n = 0;
    in_valid = 1'b1;
    in_data  = row_val(r);
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("wr_ready_r%0d", r), 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] data,
                             input int inner, input int outer);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, data);
    check({tag, "_inner"}, 64'(index_inner), 64'(inner));
    check({tag, "_outer"}, 64'(index_outer), 64'(outer));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int cols[4];
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    range_inner = 3'd4; range_outer = 3'd1; stride = 3'd1;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_inner", 64'(index_inner), 64'd0);
    check("rst_outer", 64'(index_outer), 64'd0);

    // Identity transpose, back-to-back rows, fill latency
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      in_data  = row_val(r);
      check($sformatf("id_ready_r%0d", r), 64'(in_ready), 64'd1);
      check($sformatf("id_pre_valid_r%0d", r), 64'(out_valid), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    check("id_fill_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 4; c++) expect_beat($sformatf("id_c%0d", c), col_val(0, c), c, 0);
    check("id_released", 64'(out_valid), 64'd0);

    // Stride 2 wraps modulo 4: columns 0,2,0,2
    stride = 3'd2;
    for (int r = 4; r < 8; r++) write_row(r);
    cols = '{0, 2, 0, 2};
    for (int k = 0; k < 4; k++) expect_beat($sformatf("st_k%0d", k), col_val(4, cols[k]), k, 0);
    check("st_released", 64'(out_valid), 64'd0);

    // Replay: 2 columns x 3 passes
    range_inner = 3'd2; range_outer = 3'd3; stride = 3'd1;
    for (int r = 8; r < 12; r++) write_row(r);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) check("rp_valid_before_last", 64'(out_valid), 64'd1);
      expect_beat($sformatf("rp_k%0d", k), col_val(8, k % 2), k % 2, k / 2);
    end
    check("rp_released", 64'(out_valid), 64'd0);

    // Backpressure: both banks fill, in_ready drops after 8 rows
    range_inner = 3'd4; range_outer = 3'd1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = row_val(12 + k);
      check($sformatf("bp_ready_k%0d", k), 64'(in_ready), 64'd1);
      tick();
    end
    in_data = row_val(20);
    check("bp_ready_full", 64'(in_ready), 64'd0);
    tick();
    check("bp_ready_hold", 64'(in_ready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) check("bp_ready_before_rel", 64'(in_ready), 64'd0);
      expect_beat($sformatf("bp_t0_c%0d", c), col_val(12, c), c, 0);
    end
    check("bp_ready_after_rel", 64'(in_ready), 64'd1);
    tick();
    in_data = row_val(21);
    check("bp_ready_r21", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) expect_beat($sformatf("bp_t1_c%0d", c), col_val(16, c), c, 0);

    // Zero ranges: one beat of column 0 per tile
    range_inner = 3'd0; range_outer = 3'd0;
    for (int r = 22; r < 24; r++) write_row(r);
    expect_beat("zr_t0", col_val(20, 0), 0, 0);
    check("zr_t0_released", 64'(out_valid), 64'd0);
    check("zr_t0_inner", 64'(index_inner), 64'd0);
    for (int r = 24; r < 28; r++) write_row(r);
    expect_beat("zr_t1", col_val(24, 0), 0, 0);
    check("zr_t1_released", 64'(out_valid), 64'd0);

    // Mid-stream reset discards a full bank and a partial bank
    range_inner = 3'd4; range_outer = 3'd1; stride = 3'd1;
    for (int r = 28; r < 34; r++) write_row(r);
    check("mr_pre_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    rst_n = 1'b1;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_inner", 64'(index_inner), 64'd0);
    check("mr_outer", 64'(index_outer), 64'd0);
    for (int r = 34; r < 38; r++) write_row(r);
    for (int c = 0; c < 4; c++) expect_beat($sformatf("mr_c%0d", c), col_val(34, c), c, 0);
    check("mr_released", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
